vend_ctrl: RTL

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_ctrl_pkg.sv | 50 +++++
 rtl/vend_ctrl_if.sv | 32 +++
 rtl/vend_coin_arb.sv | 62 ++++++
 rtl/vend_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vend_ctrl_pkg.sv
// Shared types, coin constants and small helpers for the vending controller.
// The state encoding and credit width are common to the top and coin arbiter.
package vend_ctrl_pkg;

  localparam int CREDIT_W = 5;

  localparam logic [CREDIT_W-1:0] COIN_1_VAL = 5'd1;
  localparam logic [CREDIT_W-1:0] COIN_2_VAL = 5'd2;
  localparam logic [CREDIT_W-1:0] COIN_5_VAL = 5'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_1    = 2'd1,
    GNT_2    = 2'd2,
    GNT_5    = 2'd3
  } grant_t;

  function automatic logic [CREDIT_W-1:0] grant_value(input grant_t grant);
    logic [CREDIT_W-1:0] val;
    case (grant)
      GNT_1:   val = COIN_1_VAL;
      GNT_2:   val = COIN_2_VAL;
      GNT_5:   val = COIN_5_VAL;
      default: val = 5'd0;
    endcase
    return val;
  endfunction

  // Saturating up/down step; a simultaneous increment and decrement cancel out.
  function automatic logic [1:0] pend_next(input logic [1:0] cur, input logic inc, input logic dec);
    logic [1:0] nxt;
    if (inc && !dec) begin
      nxt = (cur == 2'd3) ? 2'd3 : cur + 2'd1;
    end else if (!inc && dec) begin
      nxt = cur - 2'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Coin, price, dispenser and change-hopper signals of the vending controller.
// The slave modport is the controller's view; master is the surrounding machine.
interface vend_ctrl_if;
  import vend_ctrl_pkg::*;

  logic                i_1yuan;
  logic                i_2yuan;
  logic                i_5yuan;
  logic [3:0]          i_price;
  logic                i_cancel;
  logic                o_vend_req;
  logic                i_vend_ack;
  logic                o_chg_1yuan;
  logic                o_chg_2yuan;
  logic                o_chg_5yuan;
  logic                i_chg_ready;
  logic [CREDIT_W-1:0] o_credit;
  logic                o_busy;
  logic                o_done;
  logic                o_coin_err;

  modport master (
    output i_1yuan, i_2yuan, i_5yuan, i_price, i_cancel, i_vend_ack, i_chg_ready,
    input  o_vend_req, o_chg_1yuan, o_chg_2yuan, o_chg_5yuan, o_credit, o_busy, o_done, o_coin_err
  );

  modport slave (
    input  i_1yuan, i_2yuan, i_5yuan, i_price, i_cancel, i_vend_ack, i_chg_ready,
    output o_vend_req, o_chg_1yuan, o_chg_2yuan, o_chg_5yuan, o_credit, o_busy, o_done, o_coin_err
  );

endinterface

// File: rtl/vend_coin_arb.sv
// Per-denomination pending coin counters with a fixed-priority (5 > 2 > 1) grant.
// Grants come from registered counts only, so a coin is credited one edge after its pulse.
module vend_coin_arb
  import vend_ctrl_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_1yuan,
  input  logic   i_2yuan,
  input  logic   i_5yuan,
  input  logic   i_grant_en,
  output grant_t o_grant,
  output logic   o_coin_err
);

  logic [1:0] pend1_r;
  logic [1:0] pend2_r;
  logic [1:0] pend5_r;
  logic       coin_err_r;
  grant_t     grant_s;
  logic       ovf_s;

  // Pick the highest-value held coin when the controller can take one.
  always_comb begin
    grant_s = GNT_NONE;
    if (!i_grant_en) begin
      grant_s = GNT_NONE;
    end else if (pend5_r != 2'd0) begin
      grant_s = GNT_5;
    end else if (pend2_r != 2'd0) begin
      grant_s = GNT_2;
    end else if (pend1_r != 2'd0) begin
      grant_s = GNT_1;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // A coin is lost only when it lands on a full counter that is not draining this cycle.
  assign ovf_s = (i_1yuan && (grant_s != GNT_1) && (pend1_r == 2'd3)) ||
                 (i_2yuan && (grant_s != GNT_2) && (pend2_r == 2'd3)) ||
                 (i_5yuan && (grant_s != GNT_5) && (pend5_r == 2'd3));

  // Pending counters and the sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend1_r    <= 2'd0;
      pend2_r    <= 2'd0;
      pend5_r    <= 2'd0;
      coin_err_r <= 1'b0;
    end else begin
      pend1_r    <= pend_next(pend1_r, i_1yuan, grant_s == GNT_1);
      pend2_r    <= pend_next(pend2_r, i_2yuan, grant_s == GNT_2);
      pend5_r    <= pend_next(pend5_r, i_5yuan, grant_s == GNT_5);
      coin_err_r <= coin_err_r | ovf_s;
    end
  end

  assign o_grant    = grant_s;
  assign o_coin_err = coin_err_r;

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: transaction FSM, credit accumulation and change payout.
// All outputs are registered from the next-state decode so they align with the state.
module vend_ctrl
  import vend_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  vend_ctrl_if.slave bus
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CREDIT_W-1:0] credit_r;
  logic [CREDIT_W-1:0] credit_nxt_s;
  logic [CREDIT_W-1:0] change_r;
  logic [CREDIT_W-1:0] change_nxt_s;
  logic [3:0]          price_r;
  logic [3:0]          price_eff_s;
  logic [CREDIT_W-1:0] price_ext_s;
  logic                grant_en_s;
  grant_t              grant_s;
  logic                coin_err_s;
  logic                pay1_s;
  logic                pay2_s;
  logic                pay5_s;
  logic [CREDIT_W-1:0] pay_val_s;
  logic [CREDIT_W-1:0] change_left_s;
  logic [CREDIT_W-1:0] vend_change_s;
  logic                chg1_nxt_s;
  logic                chg2_nxt_s;
  logic                chg5_nxt_s;
  logic                vend_req_r;
  logic                busy_r;
  logic                done_r;
  logic                chg1_r;
  logic                chg2_r;
  logic                chg5_r;

  vend_coin_arb u_coin_arb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_1yuan    (bus.i_1yuan),
    .i_2yuan    (bus.i_2yuan),
    .i_5yuan    (bus.i_5yuan),
    .i_grant_en (grant_en_s),
    .o_grant    (grant_s),
    .o_coin_err (coin_err_s)
  );

  assign price_eff_s   = (bus.i_price == 4'd0) ? 4'd1 : bus.i_price;
  assign price_ext_s   = {1'b0, price_r};
  assign vend_change_s = credit_r - price_ext_s;
  assign change_left_s = change_r - pay_val_s;

  // Coins are taken in IDLE, or in ACCEPT while short of price and not cancelling.
  always_comb begin
    grant_en_s = 1'b0;
    case (state_r)
      ST_IDLE:   grant_en_s = 1'b1;
      ST_ACCEPT: grant_en_s = !bus.i_cancel && (credit_r < price_ext_s);
      default:   grant_en_s = 1'b0;
    endcase
  end

  // Largest change coin that still fits the remaining change.
  always_comb begin
    pay1_s    = 1'b0;
    pay2_s    = 1'b0;
    pay5_s    = 1'b0;
    pay_val_s = 5'd0;
    if (change_r >= COIN_5_VAL) begin
      pay5_s    = 1'b1;
      pay_val_s = COIN_5_VAL;
    end else if (change_r >= COIN_2_VAL) begin
      pay2_s    = 1'b1;
      pay_val_s = COIN_2_VAL;
    end else if (change_r >= COIN_1_VAL) begin
      pay1_s    = 1'b1;
      pay_val_s = COIN_1_VAL;
    end else begin
      pay_val_s = 5'd0;
    end
  end

  // Next-state, credit, change and change-pulse decode.
  always_comb begin
    state_nxt_s  = state_r;
    credit_nxt_s = credit_r + grant_value(grant_s);
    change_nxt_s = change_r;
    chg1_nxt_s   = 1'b0;
    chg2_nxt_s   = 1'b0;
    chg5_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_s != GNT_NONE) begin
          state_nxt_s = ST_ACCEPT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCEPT: begin
        if (bus.i_cancel) begin
          state_nxt_s  = ST_CHANGE;
          change_nxt_s = credit_r;
        end else if (credit_r >= price_ext_s) begin
          state_nxt_s = ST_VEND;
        end else begin
          state_nxt_s = ST_ACCEPT;
        end
      end
      ST_VEND: begin
        if (bus.i_vend_ack) begin
          change_nxt_s = vend_change_s;
          state_nxt_s  = (vend_change_s == 5'd0) ? ST_DONE : ST_CHANGE;
        end else begin
          state_nxt_s = ST_VEND;
        end
      end
      ST_CHANGE: begin
        if (bus.i_chg_ready) begin
          chg1_nxt_s   = pay1_s;
          chg2_nxt_s   = pay2_s;
          chg5_nxt_s   = pay5_s;
          change_nxt_s = change_left_s;
          state_nxt_s  = (change_left_s == 5'd0) ? ST_DONE : ST_CHANGE;
        end else begin
          state_nxt_s = ST_CHANGE;
        end
      end
      ST_DONE: begin
        credit_nxt_s = 5'd0;
        state_nxt_s  = ST_IDLE;
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        credit_nxt_s = 5'd0;
        change_nxt_s = 5'd0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      credit_r   <= 5'd0;
      change_r   <= 5'd0;
      price_r    <= 4'd0;
      vend_req_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      chg1_r     <= 1'b0;
      chg2_r     <= 1'b0;
      chg5_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      credit_r   <= credit_nxt_s;
      change_r   <= change_nxt_s;
      price_r    <= (state_r == ST_IDLE) ? price_eff_s : price_r;
      vend_req_r <= (state_nxt_s == ST_VEND);
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= (state_nxt_s == ST_DONE);
      chg1_r     <= chg1_nxt_s;
      chg2_r     <= chg2_nxt_s;
      chg5_r     <= chg5_nxt_s;
    end
  end

  assign bus.o_vend_req  = vend_req_r;
  assign bus.o_chg_1yuan = chg1_r;
  assign bus.o_chg_2yuan = chg2_r;
  assign bus.o_chg_5yuan = chg5_r;
  assign bus.o_credit    = credit_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_done      = done_r;
  assign bus.o_coin_err  = coin_err_s;

endmodule
